envelope_vca: RTL and testbench

- Voltage-controlled-amplifier stage directly downstream of the ADSR envelope generator.
- Multiplies an oscillator sample stream by the envelope's 8-bit amplitude and passes the scaled samples to the mixer/DAC path.
- Slew-limits gain changes per sample to suppress zipper noise.
- Two-stage valid/ready elastic pipeline with an idle flag so voice allocation can reclaim silent voices.

---
 rtl/envelope_vca_pkg.sv | 14 +
 rtl/vca_gain_slew.sv | 49 ++++
 rtl/envelope_vca.sv | 102 ++++++++++
 tb/tb_envelope_vca.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_vca_pkg.sv
// Shared definitions for amplitude consumers (VCA, mixer, tremolo).
package envelope_vca_pkg;

  localparam int SAMPLE_BITS_DEF = 16;
  localparam int AMP_BITS_DEF    = 8;
  localparam int COEFF_BITS      = 9;
  localparam int UNITY_COEFF     = 256;

  // Map an 8-bit amplitude to a 9-bit coefficient so that 255 becomes 256 (exact unity).
  function automatic logic [COEFF_BITS-1:0] amp_to_coeff(input logic [7:0] a);
    return {1'b0, a} + {{(COEFF_BITS-1){1'b0}}, a[7]};
  endfunction

endpackage

// File: rtl/vca_gain_slew.sv
// Gain register with per-accept slew limiting toward the envelope amplitude.
module vca_gain_slew
  import envelope_vca_pkg::*;
#(
  parameter int AMP_BITS  = AMP_BITS_DEF,
  parameter int SLEW_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic [AMP_BITS-1:0]   amplitude_i,
  output logic [AMP_BITS-1:0]   gain_next_o,
  output logic [COEFF_BITS-1:0] coeff_o
);

  localparam logic [AMP_BITS:0]   STEP_X = (AMP_BITS+1)'(SLEW_STEP);
  localparam logic [AMP_BITS-1:0] STEP_A = AMP_BITS'(SLEW_STEP);

  logic [AMP_BITS-1:0] gain_q, gain_d;
  logic [AMP_BITS:0]   amp_x, gain_x, diff_up, diff_dn;

  // Move the gain at most STEP toward the amplitude, only when a sample is accepted.
  always_comb begin
    amp_x   = {1'b0, amplitude_i};
    gain_x  = {1'b0, gain_q};
    diff_up = amp_x - gain_x;
    diff_dn = gain_x - amp_x;
    gain_d  = gain_q;
    if (accept_i) begin
      if (amp_x >= gain_x) begin
        if (diff_up <= STEP_X) gain_d = amplitude_i;
        else                   gain_d = gain_q + STEP_A;
      end else begin
        if (diff_dn <= STEP_X) gain_d = amplitude_i;
        else                   gain_d = gain_q - STEP_A;
      end
    end
  end

  // Gain state; cleared to silence on reset.
  always_ff @(posedge clk) begin
    if (!rst) gain_q <= '0;
    else      gain_q <= gain_d;
  end

  assign gain_next_o = gain_d;
  assign coeff_o     = amp_to_coeff(gain_d);

endmodule

// File: rtl/envelope_vca.sv
// Envelope VCA: slewed gain times signed sample, two-stage elastic pipeline, idle flag.
module envelope_vca
  import envelope_vca_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int AMP_BITS    = AMP_BITS_DEF,
  parameter int SLEW_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AMP_BITS-1:0]    amplitude,
  input  logic [SAMPLE_BITS-1:0] in_sample,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [SAMPLE_BITS-1:0] out_sample,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   idle
);

  localparam int PW = SAMPLE_BITS + 10;

  // Signed multiply by a non-negative coefficient, then floor-divide by 256.
  function automatic logic signed [SAMPLE_BITS-1:0] scale_floor(
    input logic signed [SAMPLE_BITS-1:0] s,
    input logic [COEFF_BITS-1:0]         c
  );
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    prod    = PW'(s) * PW'($signed({1'b0, c}));
    shifted = prod >>> 8;
    return shifted[SAMPLE_BITS-1:0];
  endfunction

  logic                          ready1, ready2, accept;
  logic [AMP_BITS-1:0]           gain_next;
  logic [COEFF_BITS-1:0]         coeff_next;

  logic signed [SAMPLE_BITS-1:0] sample_p1_q;
  logic [COEFF_BITS-1:0]         coeff_p1_q;
  logic                          vld_p1_q, vld_p1_d;
  logic signed [SAMPLE_BITS-1:0] out_p2_q, out_p2_d;
  logic                          vld_p2_q, vld_p2_d;
  logic                          idle_q, idle_d;

  assign ready2   = !vld_p2_q || out_ready;
  assign ready1   = !vld_p1_q || ready2;
  assign in_ready = ready1 && rst;
  assign accept   = in_valid && in_ready;

  vca_gain_slew #(
    .AMP_BITS  (AMP_BITS),
    .SLEW_STEP (SLEW_STEP)
  ) u_gain (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .amplitude_i (amplitude),
    .gain_next_o (gain_next),
    .coeff_o     (coeff_next)
  );

  // Next-state for the valid chain, the scaled result and the idle flag.
  always_comb begin
    vld_p1_d = ready1 ? accept   : vld_p1_q;
    vld_p2_d = ready2 ? vld_p1_q : vld_p2_q;
    idle_d   = (gain_next == '0) && !vld_p1_d && !vld_p2_d;
    out_p2_d = scale_floor(sample_p1_q, coeff_p1_q);
  end

  // Control state: stage valids and idle; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      idle_q   <= idle_d;
    end
  end

  // Stage 1 boundary: capture accepted sample with its coefficient.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_p1_q <= $signed(in_sample);
      coeff_p1_q  <= coeff_next;
    end
  end

  // Stage 2 boundary: load the scaled product when stage 1 holds data and stage 2 can move.
  always_ff @(posedge clk) begin
    if (!rst)                      out_p2_q <= '0;
    else if (ready2 && vld_p1_q)   out_p2_q <= out_p2_d;
  end

  assign out_sample = out_p2_q;
  assign out_valid  = vld_p2_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Scoreboard bench for envelope_vca: a unity-slew and a slow-slew instance share stimulus.
module tb_envelope_vca;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  amplitude;
  logic [15:0] in_sample;
  logic        in_ready_u, out_valid_u, idle_u;
  logic        in_ready_s, out_valid_s, idle_s;
  logic [15:0] out_sample_u, out_sample_s;

  always #5 clk = ~clk;

  envelope_vca #(.SAMPLE_BITS(16), .AMP_BITS(8), .SLEW_STEP(255)) u_unity (
    .clk(clk), .rst(rst), .amplitude(amplitude), .in_sample(in_sample),
    .in_valid(in_valid), .in_ready(in_ready_u), .out_sample(out_sample_u),
    .out_valid(out_valid_u), .out_ready(out_ready), .idle(idle_u));

  envelope_vca #(.SAMPLE_BITS(16), .AMP_BITS(8), .SLEW_STEP(1)) u_slew (
    .clk(clk), .rst(rst), .amplitude(amplitude), .in_sample(in_sample),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_sample(out_sample_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .idle(idle_s));

  int n_checks = 0;
  int n_fail   = 0;
  int q_u[$], q_s[$], log_u[$], log_s[$];
  int g_u = 0, g_s = 0;
  bit mon_en = 0;
  bit hold_u = 0, hold_s = 0;
  logic [15:0] held_u, held_s;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference gain: jump to target when within step, else move one step toward it.
  function automatic int slew_model(input int g, input int a, input int step);
    int d = a - g;
    if (d <= step && d >= -step) return a;
    if (d > 0) return g + step;
    return g - step;
  endfunction

  // Reference scaling: sample * coefficient / 256, rounded toward minus infinity.
  function automatic int scale_model(input int s, input int g);
    int c = g + ((g >= 128) ? 1 : 0);
    int p = s * c;
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  // Monitor: evaluates what the upcoming rising edge will do, using mid-cycle values.
  always @(negedge clk) begin
    if (mon_en) begin
      check("idle_unity", int'(idle_u), (g_u == 0 && q_u.size() == 0) ? 1 : 0);
      check("idle_slew",  int'(idle_s), (g_s == 0 && q_s.size() == 0) ? 1 : 0);
      check("in_ready", int'(in_ready_u),
            (rst && !(q_u.size() == 2 && !out_ready)) ? 1 : 0);
      if (hold_u) check("hold_unity", int'(out_sample_u), int'(held_u));
      if (hold_s) check("hold_slew",  int'(out_sample_s), int'(held_s));
      hold_u = rst && out_valid_u && !out_ready;
      hold_s = rst && out_valid_s && !out_ready;
      held_u = out_sample_u;
      held_s = out_sample_s;
      if (!rst) begin
        q_u.delete(); q_s.delete();
        g_u = 0; g_s = 0;
      end else begin
        if (out_valid_u && out_ready) begin
          if (q_u.size() == 0) check("unexpected_out_unity", int'($signed(out_sample_u)), 99999);
          else check("out_unity", int'($signed(out_sample_u)), q_u.pop_front());
          log_u.push_back(int'($signed(out_sample_u)));
        end
        if (out_valid_s && out_ready) begin
          if (q_s.size() == 0) check("unexpected_out_slew", int'($signed(out_sample_s)), 99999);
          else check("out_slew", int'($signed(out_sample_s)), q_s.pop_front());
          log_s.push_back(int'($signed(out_sample_s)));
        end
        if (in_valid && in_ready_u) begin
          g_u = slew_model(g_u, int'(amplitude), 255);
          g_s = slew_model(g_s, int'(amplitude), 1);
          q_u.push_back(scale_model(int'($signed(in_sample)), g_u));
          q_s.push_back(scale_model(int'($signed(in_sample)), g_s));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input logic [7:0] a);
    bit done = 0;
    in_sample = s;
    amplitude = a;
    in_valid  = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready_u) begin
        tick();
        done = 1;
      end
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      tick();
      if (q_u.size() == 0 && q_s.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    amplitude = 8'd200; in_sample = 16'h1234;

    // Reset held with valid input present
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en = 1;
      check("rst_in_ready",   int'(in_ready_u),   0);
      check("rst_out_valid",  int'(out_valid_u),  0);
      check("rst_out_sample", int'(out_sample_u), 0);
      check("rst_idle",       int'(idle_u),       1);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("post_rst_in_ready", int'(in_ready_u), 1);

    // Slow slew upward, positive samples
    log_s.delete();
    for (int i = 0; i < 6; i++) send(16'd1000, 8'd4);
    drain();
    check_log("slew_pos", log_s, '{3, 7, 11, 15, 15, 15});

    // Slow slew upward, negative samples (floor)
    do_reset();
    log_s.delete();
    for (int i = 0; i < 6; i++) send(-16'sd1000, 8'd4);
    drain();
    check_log("slew_neg", log_s, '{-4, -8, -12, -16, -16, -16});

    // Unity gain with latency check, then half gain on a negative sample
    do_reset();
    log_u.delete();
    send(16'h4000, 8'd255);
    check("lat_not_yet", int'(out_valid_u), 0);
    tick();
    check("lat_valid", int'(out_valid_u), 1);
    check("lat_value", int'(out_sample_u), 16'h4000);
    send(16'hC000, 8'd128);
    drain();
    check_log("unity", log_u, '{16384, -8256});

    // Back-pressure: two samples buffered, input stalls, output holds
    log_u.delete();
    send(16'd1, 8'd255);
    out_ready = 1'b0;
    send(16'd2, 8'd255);
    in_sample = 16'd3; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_in_ready",   int'(in_ready_u),   0);
      check("bp_out_valid",  int'(out_valid_u),  1);
      check("bp_out_sample", int'(out_sample_u), 1);
    end
    out_ready = 1'b1;
    send(16'd3, 8'd255);
    send(16'd4, 8'd255);
    send(16'd5, 8'd255);
    drain();
    check_log("bp_order", log_u, '{1, 2, 3, 4, 5});

    // Idle after silencing, then wake on a nonzero amplitude
    log_u.delete();
    send(16'd1234, 8'd0);
    drain();
    tick();
    check("idle_set", int'(idle_u), 1);
    check_log("silence", log_u, '{0});
    send(16'd100, 8'd16);
    check("idle_clear", int'(idle_u), 0);
    drain();

    // Reset with both stages full: nothing stale may emerge
    out_ready = 1'b0;
    send(16'd7, 8'd255);
    send(16'd8, 8'd255);
    rst = 1'b0;
    tick();
    check("mid_rst_out_valid", int'(out_valid_u), 0);
    check("mid_rst_idle",      int'(idle_u),      1);
    rst = 1'b1;
    out_ready = 1'b1;
    log_u.delete();
    repeat (5) tick();
    send(16'd9, 8'd255);
    drain();
    check_log("after_mid_rst", log_u, '{9});

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      amplitude = 8'($urandom_range(0, 255));
      in_sample = 16'($urandom);
      rst       = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
